// File: rtl/pipe_ctrl.sv
// -----------------------------------------------------------------------------
// pipe_ctrl -- central pipeline controller for the five-stage MIPS32 core.
//
// Merges stall requests from IF/ID/EX/MEM into one per-stage hold vector,
// sequences a one-cycle flush with a redirect PC when an exception commits,
// and raises a sticky hang flag when a stall never releases.
//
// Ports:
//   clk            clock
//   rst            synchronous, active-high reset
//   stallreq_if    fetch stage stall request
//   stallreq_id    decode stage stall request (load-use)
//   stallreq_ex    execute stage stall request (multi-cycle op)
//   stallreq_mem   memory stage stall request
//   excp_valid     exception committed in MEM this cycle
//   excp_vector    handler address, valid with excp_valid
//   stall[5:0]     hold per register: [0]=PC [1]=IF/ID [2]=ID/EX [3]=EX/MEM
//                  [4]=MEM/WB [5]=WB
//   flush          clear all pipeline registers to NOP (one cycle)
//   new_pc         redirect target, valid while flush=1, held afterwards
//   stall_timeout  sticky hang indicator, cleared only by rst
//   busy_state     current FSM state (RUN=0, STALL=1, FLUSH=2)
//
// Optional feature (macro PIPE_CTRL_PERF_EN):
//   perf_stall_cycles[31:0]  cycles with a nonzero stall vector (wraps)
//   perf_flush_count[15:0]   number of FLUSH entries (wraps)
// -----------------------------------------------------------------------------
module pipe_ctrl #(
  parameter int STALL_TIMEOUT = 1024,
  parameter int PC_W          = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stallreq_if,
  input  logic            stallreq_id,
  input  logic            stallreq_ex,
  input  logic            stallreq_mem,
  input  logic            excp_valid,
  input  logic [PC_W-1:0] excp_vector,
  output logic [5:0]      stall,
  output logic            flush,
  output logic [PC_W-1:0] new_pc,
  output logic            stall_timeout,
  output logic [1:0]      busy_state
`ifdef PIPE_CTRL_PERF_EN
  ,
  output logic [31:0]     perf_stall_cycles,
  output logic [15:0]     perf_flush_count
`endif
);

  localparam logic [15:0] TIMEOUT_C = 16'(STALL_TIMEOUT);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] new_pc_q, new_pc_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            timeout_q, timeout_d;
  logic [5:0]      req_vec;
  logic            any_req;

  assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;

  // Deepest requester wins: a stage stalls itself and everything upstream.
  // An exception or an ongoing flush overrides every request.
  always_comb begin
    // NOTE: every combinationally assigned signal gets a default first so no
    // path leaves it unassigned and no latch is inferred.
    req_vec = 6'b000000;
    if (stallreq_mem)     req_vec = 6'b011111;
    else if (stallreq_ex) req_vec = 6'b001111;
    else if (stallreq_id) req_vec = 6'b000111;
    else if (stallreq_if) req_vec = 6'b000011;

    stall = req_vec;
    if (state_q == ST_FLUSH || excp_valid) stall = 6'b000000;
  end

  // Next-state logic. An exception is only accepted outside FLUSH: the flush
  // itself clears the stage that raised a second exception.
  always_comb begin
    state_d  = state_q;
    new_pc_d = new_pc_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (excp_valid) begin
          state_d  = ST_FLUSH;
          new_pc_d = excp_vector;
        end else if (any_req) begin
          state_d = ST_STALL;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FLUSH: state_d = ST_RUN;
      default:  state_d = ST_RUN;  // unused encoding recovers to RUN
    endcase
  end

  // Hang watchdog: counts consecutive stalled cycles, saturating at the
  // threshold. The flag latches one cycle after the count reaches it.
  always_comb begin
    cnt_d = 16'd0;
    if (stall != 6'b000000)
      cnt_d = (cnt_q >= TIMEOUT_C) ? cnt_q : cnt_q + 16'd1;
    timeout_d = timeout_q | (cnt_q == TIMEOUT_C);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q   <= ST_RUN;
      new_pc_q  <= '0;
      cnt_q     <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      new_pc_q  <= new_pc_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign flush         = (state_q == ST_FLUSH);
  assign new_pc        = new_pc_q;
  assign stall_timeout = timeout_q;
  assign busy_state    = state_q;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_flush_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_q <= 32'd0;
      perf_flush_q <= 16'd0;
    end else begin
      if (stall != 6'b000000)
        perf_stall_q <= perf_stall_q + 32'd1;
      if (state_d == ST_FLUSH && state_q != ST_FLUSH)
        perf_flush_q <= perf_flush_q + 16'd1;
    end
  end

  assign perf_stall_cycles = perf_stall_q;
  assign perf_flush_count  = perf_flush_q;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl -- self-checking bench for pipe_ctrl (STALL_TIMEOUT=8).
// Directed scenarios followed by randomized stimulus, all compared against a
// behavioural model of the controller kept in this file.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl;

  localparam int T    = 8;
  localparam int PC_W = 32;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            stallreq_if = 1'b0, stallreq_id = 1'b0;
  logic            stallreq_ex = 1'b0, stallreq_mem = 1'b0;
  logic            excp_valid = 1'b0;
  logic [PC_W-1:0] excp_vector = '0;
  logic [5:0]      stall;
  logic            flush;
  logic [PC_W-1:0] new_pc;
  logic            stall_timeout;
  logic [1:0]      busy_state;
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0]     perf_stall_cycles;
  logic [15:0]     perf_flush_count;
`endif

  pipe_ctrl #(.STALL_TIMEOUT(T), .PC_W(PC_W)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallreq_if   (stallreq_if),
    .stallreq_id   (stallreq_id),
    .stallreq_ex   (stallreq_ex),
    .stallreq_mem  (stallreq_mem),
    .excp_valid    (excp_valid),
    .excp_vector   (excp_vector),
    .stall         (stall),
    .flush         (flush),
    .new_pc        (new_pc),
    .stall_timeout (stall_timeout),
    .busy_state    (busy_state)
`ifdef PIPE_CTRL_PERF_EN
    ,
    .perf_stall_cycles (perf_stall_cycles),
    .perf_flush_count  (perf_flush_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural model: mode 0=running, 1=stalled, 2=flushing.
  int          m_mode;
  logic [31:0] m_pc;
  int          m_run;        // consecutive stalled cycles, saturating at T
  bit          m_to;
  int unsigned m_perf_stall;
  int unsigned m_perf_flush;

  task automatic model_reset();
    m_mode = 0; m_pc = '0; m_run = 0; m_to = 0;
    m_perf_stall = 0; m_perf_flush = 0;
  endtask

  // Called at posedge+1: drives inputs, checks mid-cycle, advances the model
  // across the next edge, and returns at posedge+1.
  task automatic step(input bit r_if, input bit r_id, input bit r_ex, input bit r_mem,
                      input bit e, input logic [31:0] v);
    int         depth;
    logic [5:0] ev;
    int         nxt;
    stallreq_if = r_if; stallreq_id = r_id; stallreq_ex = r_ex; stallreq_mem = r_mem;
    excp_valid = e; excp_vector = v;
    #4;
    depth = r_mem ? 4 : r_ex ? 3 : r_id ? 2 : r_if ? 1 : 0;
    ev = (m_mode == 2 || e || depth == 0) ? 6'd0 : 6'((1 << (depth + 1)) - 1);
    check("stall", stall, ev);
    check("flush", flush, m_mode == 2);
    check("new_pc", new_pc, m_pc);
    check("busy_state", busy_state, m_mode[1:0]);
    check("stall_timeout", stall_timeout, m_to);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall_cycles", perf_stall_cycles, m_perf_stall);
    check("perf_flush_count", perf_flush_count, m_perf_flush & 32'hFFFF);
`endif
    if (m_mode == 2)            nxt = 0;
    else if (e)                 nxt = 2;
    else if (r_if | r_id | r_ex | r_mem) nxt = 1;
    else                        nxt = 0;
    if (nxt == 2) begin
      m_pc = v;
      m_perf_flush++;
    end
    if (m_run == T) m_to = 1;
    if (ev != 0) begin
      m_run = (m_run < T) ? m_run + 1 : T;
      m_perf_stall++;
    end else begin
      m_run = 0;
    end
    m_mode = nxt;
    @(posedge clk); #1;
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    stallreq_if = 1'b1; stallreq_id = 1'b1; stallreq_ex = 1'b1; stallreq_mem = 1'b1;
    excp_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    model_reset();
    @(posedge clk); #1;

    // Reset with all requests high, then idle.
    do_reset(2);
    step(0, 0, 0, 0, 0, 0);
    check("rst_busy_state", busy_state, 2'd0);
    check("rst_new_pc", new_pc, 32'h0);

    // Priority: id+mem, drop mem, drop id.
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Exception beats an EX stall.
    step(0, 0, 1, 0, 1, 32'hBFC00380);
    check("excp_flush", flush, 1'b1);
    check("excp_new_pc", new_pc, 32'hBFC00380);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Back-to-back exceptions: only the first is taken.
    step(0, 0, 0, 0, 1, 32'h80000180);
    step(0, 0, 0, 0, 1, 32'h80000200);
    step(0, 0, 0, 0, 0, 0);
    check("b2b_new_pc", new_pc, 32'h80000180);
    check("b2b_flush", flush, 1'b0);

    // Timeout: 9 stalled cycles set the sticky flag.
    do_reset(1);
    step(0, 0, 0, 0, 0, 0);
    repeat (9) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    check("to_set", stall_timeout, 1'b1);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h1000);
    step(0, 0, 0, 0, 0, 0);
    check("to_sticky", stall_timeout, 1'b1);

    // 7 stalled, 1 free, 7 stalled: never times out.
    do_reset(1);
    repeat (7) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (7) step(1, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    check("to_clear", stall_timeout, 1'b0);

    // Perf counters: 5 stalled cycles + 2 exceptions, then rst mid-FLUSH.
    do_reset(1);
    repeat (5) step(0, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h2000);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 32'h3000);
    step(0, 0, 0, 0, 0, 0);
`ifdef PIPE_CTRL_PERF_EN
    check("perf_stall5", perf_stall_cycles, 32'd5);
    check("perf_flush2", perf_flush_count, 16'd2);
`endif
    step(0, 0, 0, 0, 1, 32'h4000);
    check("pre_rst_flush", flush, 1'b1);
    do_reset(1);
    step(0, 0, 0, 0, 0, 0);
    check("rst_mid_flush", flush, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset($urandom_range(1, 2));
      end else begin
        step($urandom_range(0, 99) < 30, $urandom_range(0, 99) < 15,
             $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 10,
             $urandom_range(0, 99) < 6, $urandom);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
- Central pipeline controller for the five-stage MIPS32 core.
- Arbitrates stall requests from IF/ID/EX/MEM into one per-stage stall vector that freezes pc_reg, if_id, id_ex, ex_mem and mem_wb.
- Sequences a one-cycle pipeline flush with redirect PC on exception.
- Watches for stalls that never release.

Parameters:
- STALL_TIMEOUT, 1024: consecutive stalled cycles after which the hang flag sets. Range 1..65535.
- PC_W, 32: width of exception vector and redirect PC.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- stallreq_if  in  1  fetch stage requests stall
- stallreq_id  in  1  decode stage requests stall (load-use)
- stallreq_ex  in  1  execute stage requests stall (multi-cycle op)
- stallreq_mem  in  1  memory stage requests stall
- excp_valid  in  1  exception committed in MEM this cycle
- excp_vector  in  PC_W  handler address, valid with excp_valid
- stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; 1 = hold register
- flush  out  1  clear all pipeline registers to NOP
- new_pc  out  PC_W  redirect target, valid while flush=1
- stall_timeout  out  1  sticky hang indicator
- busy_state  out  2  current FSM state, for debug

Behaviour:
- Reset (rst=1 at posedge): state=RUN, stall=0, flush=0, new_pc=0, stall_timeout=0, stall counter=0, busy_state=0.
- States, with busy_state encoding: RUN=0, STALL=1, FLUSH=2. Encoding 3 is unused and recovers to RUN next cycle.
- Stall vector is combinational from current requests. Deepest requester wins:
  - mem: 011111
  - else ex: 001111
  - else id: 000111
  - else if: 000011
  - else: 000000
- Stall vector is forced to 000000 when:
  - state=FLUSH, or
  - excp_valid=1 (exception beats every stall request in the same cycle).
- RUN:
  - excp_valid=1 -> FLUSH; register new_pc<=excp_vector.
  - else any request -> STALL.
  - else stay RUN.
- STALL:
  - excp_valid=1 -> FLUSH (same capture as above).
  - else no request -> RUN.
  - else stay STALL.
  - Request source may change between cycles; the vector tracks it.
- FLUSH:
  - flush=1 for exactly one cycle; stall=0; all requests ignored.
  - Next state is RUN unconditionally.
  - excp_valid during FLUSH is ignored; the flush clears its source stage.
- flush is registered: it asserts the cycle after excp_valid is sampled. new_pc holds its value after FLUSH until the next capture.
- Stall counter: 16-bit.
  - Increments each cycle the stall vector is nonzero, saturating at STALL_TIMEOUT.
  - Clears to 0 on any cycle with zero stall vector or in FLUSH.
  - stall_timeout sets on the cycle after the counter reaches STALL_TIMEOUT. It stays 1 until rst, surviving later flushes and stall releases.
- rst asserted mid-STALL or mid-FLUSH: all state and outputs take reset values at that edge; the flush pulse is truncated.
- Latency:
  - stall: 0 cycles from request.
  - flush/new_pc: 1 cycle from excp_valid.
  - stall_timeout: STALL_TIMEOUT+1 cycles from first stalled cycle.

Optional Feature:
- Macro PIPE_CTRL_PERF_EN.
- Defined: adds output perf_stall_cycles (32) and perf_flush_count (16).
  - perf_stall_cycles increments every cycle the stall vector is nonzero.
  - perf_flush_count increments on every FLUSH entry.
  - Both wrap modulo 2^width and reset to 0 on rst.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Reset: rst=1 for 2 cycles with all requests high -> stall=000000, flush=0, new_pc=0, busy_state=0, stall_timeout=0 after release edge.
- Priority: stallreq_id=1 and stallreq_mem=1 together -> stall=011111 same cycle, busy_state=1 next. Drop mem -> stall=000111. Drop id -> stall=000000, RUN next cycle.
- Exception beats stall: stallreq_ex=1 with excp_valid=1, excp_vector=0xBFC00380 -> stall=000000 that cycle. Next cycle flush=1 and new_pc=0xBFC00380 with stall=000000 despite stallreq_ex still 1. Following cycle flush=0, stall=001111.
- Back-to-back exceptions: excp_valid high 2 consecutive cycles (vectors 0x80000180 then 0x80000200) -> single flush pulse, new_pc=0x80000180; second exception ignored.
- Timeout: STALL_TIMEOUT=8, stallreq_if held 9 cycles -> stall_timeout=1 at cycle 9. A 7-cycle stall, 1 free cycle, then a 7-cycle stall -> stall_timeout stays 0. After it sets, dropping requests keeps it at 1 until rst.
- Perf (PIPE_CTRL_PERF_EN): 5 stalled cycles + 2 exceptions -> perf_stall_cycles=5, perf_flush_count=2. rst mid-FLUSH -> flush=0 next cycle, counters=0.
